vxe_vpu_cmd_dispatch: RTL and testbench

- Receives commands from the control-unit VPU command bus (sel/ack handshake) and steers each one into a per-thread FIFO, selected by the command's thread field.
- Each VPU thread pipe drains its own FIFO through a valid/ready interface.
- Sits directly downstream of the CU VPU forwarding unit, on the VPU side of the command bus.
- Also decodes NOP commands, which are acknowledged and dropped.

---
 rtl/vxe_vpu_cmd_dispatch.sv | 101 ++++++++++
 tb/tb_vxe_vpu_cmd_dispatch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/vxe_vpu_cmd_dispatch.sv
// rtl/vxe_vpu_cmd_dispatch.sv - steers VPU command-bus transfers into per-thread FIFOs drained by valid/ready pipes
module vxe_vpu_cmd_dispatch #(
  parameter int NTHREADS   = 8,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vpu_cmd_sel,
  output logic                   o_vpu_cmd_ack,
  input  logic [4:0]             i_vpu_cmd_op,
  input  logic [2:0]             i_vpu_cmd_th,
  input  logic [47:0]            i_vpu_cmd_pl,
  output logic [NTHREADS-1:0]    o_th_vld,
  input  logic [NTHREADS-1:0]    i_th_rdy,
  output logic [5*NTHREADS-1:0]  o_th_op,
  output logic [48*NTHREADS-1:0] o_th_pl,
  output logic                   o_err_th,
  output logic                   o_busy
);
  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam int PW    = DEPTH_POW2 + 1;

  logic [PW-1:0] wrp_q [NTHREADS];
  logic [PW-1:0] rdp_q [NTHREADS];
  logic [4:0]    op_mem_q [NTHREADS][DEPTH];
  logic [47:0]   pl_mem_q [NTHREADS][DEPTH];
  logic          err_q;

  logic [NTHREADS-1:0] empty;
  logic [NTHREADS-1:0] full;
  logic [NTHREADS-1:0] push;
  logic [NTHREADS-1:0] pop;
  logic [3:0]          th_ext;
  logic                nop;
  logic                bad_th;
  logic                full_sel;
  logic                enq;

  assign th_ext = {1'b0, i_vpu_cmd_th};
  assign nop    = (i_vpu_cmd_op == 5'h00);
  assign bad_th = (th_ext >= 4'(NTHREADS));

  always_comb begin
    empty    = '0;
    full     = '0;
    full_sel = 1'b0;
    for (int t = 0; t < NTHREADS; t++) begin
      empty[t] = (wrp_q[t] == rdp_q[t]);
      full[t]  = (wrp_q[t][DEPTH_POW2-1:0] == rdp_q[t][DEPTH_POW2-1:0]) &&
                 (wrp_q[t][DEPTH_POW2] != rdp_q[t][DEPTH_POW2]);
      if (th_ext == 4'(t)) full_sel = full[t];
    end
  end

  // NOPs and bad thread IDs are always accepted so they never stall the bus.
  assign o_vpu_cmd_ack = !rst && i_vpu_cmd_sel && (nop || bad_th || !full_sel);
  assign enq           = o_vpu_cmd_ack && !nop && !bad_th;

  always_comb begin
    push    = '0;
    pop     = '0;
    o_th_op = '0;
    o_th_pl = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      push[t]           = enq && (th_ext == 4'(t));
      pop[t]            = !empty[t] && i_th_rdy[t];
      o_th_op[5*t +: 5]   = op_mem_q[t][rdp_q[t][DEPTH_POW2-1:0]];
      o_th_pl[48*t +: 48] = pl_mem_q[t][rdp_q[t][DEPTH_POW2-1:0]];
    end
  end

  assign o_th_vld = ~empty;
  assign o_busy   = ~&empty;
  assign o_err_th = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++) begin
        wrp_q[t] <= '0;
        rdp_q[t] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        if (push[t]) wrp_q[t] <= wrp_q[t] + PW'(1);
        if (pop[t])  rdp_q[t] <= rdp_q[t] + PW'(1);
      end
      if (o_vpu_cmd_ack && bad_th) err_q <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NTHREADS; t++) begin
      if (push[t]) begin
        op_mem_q[t][wrp_q[t][DEPTH_POW2-1:0]] <= i_vpu_cmd_op;
        pl_mem_q[t][wrp_q[t][DEPTH_POW2-1:0]] <= i_vpu_cmd_pl;
      end
    end
  end
endmodule

// File: tb/tb_vxe_vpu_cmd_dispatch.sv
// tb/tb_vxe_vpu_cmd_dispatch.sv - randomized scoreboard bench for vxe_vpu_cmd_dispatch
module tb_vxe_vpu_cmd_dispatch;
  localparam int NTH   = 6;
  localparam int DP2   = 2;
  localparam int DEPTH = 1 << DP2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic              ack;
  logic [4:0]        op;
  logic [2:0]        th;
  logic [47:0]       pl;
  logic [NTH-1:0]    vld;
  logic [NTH-1:0]    rdy;
  logic [5*NTH-1:0]  th_op;
  logic [48*NTH-1:0] th_pl;
  logic              err;
  logic              busy;

  vxe_vpu_cmd_dispatch #(.NTHREADS(NTH), .DEPTH_POW2(DP2)) dut (
    .clk(clk), .rst(rst),
    .i_vpu_cmd_sel(sel), .o_vpu_cmd_ack(ack),
    .i_vpu_cmd_op(op), .i_vpu_cmd_th(th), .i_vpu_cmd_pl(pl),
    .o_th_vld(vld), .i_th_rdy(rdy), .o_th_op(th_op), .o_th_pl(th_pl),
    .o_err_th(err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  logic [52:0] exp_q [NTH][$];
  logic        exp_err = 1'b0;
  logic        started = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: all comparisons happen on the falling edge, before the model pops.
  always @(negedge clk) begin
    if (started) begin
      logic exp_ack;
      logic bad_id;
      bad_id  = (int'(th) >= NTH);
      exp_ack = !rst && sel && ((op == 5'h00) || bad_id || (exp_q[int'(th) % NTH].size() < DEPTH));
      chk("ack", 64'(ack), 64'(exp_ack));
      chk("err_th", 64'(err), 64'(exp_err));
      begin
        logic any;
        any = 1'b0;
        for (int t = 0; t < NTH; t++) begin
          chk($sformatf("vld[%0d]", t), 64'(vld[t]), 64'(exp_q[t].size() != 0));
          if (exp_q[t].size() != 0) any = 1'b1;
        end
        chk("busy", 64'(busy), 64'(any));
      end
      for (int t = 0; t < NTH; t++) begin
        if (vld[t] && rdy[t] && exp_q[t].size() != 0) begin
          logic [52:0] e;
          e = exp_q[t].pop_front();
          chk($sformatf("op[%0d]", t), 64'(th_op[5*t +: 5]), 64'(e[52:48]));
          chk($sformatf("pl[%0d]", t), 64'(th_pl[48*t +: 48]), 64'(e[47:0]));
        end
      end
    end
  end

  task automatic new_cmd();
    logic [63:0] r;
    int          k;
    k = int'($urandom_range(0, 99));
    if (k < 8) th = 3'(NTH + int'($urandom_range(0, 7 - NTH)));
    else       th = 3'($urandom_range(0, NTH - 1));
    op = ($urandom_range(0, 99) < 10) ? 5'h00 : 5'($urandom_range(1, 31));
    r  = {$urandom, $urandom};
    pl = r[47:0];
  endtask

  initial begin
    logic xfer;
    logic rst_s;
    rst = 1'b1; sel = 1'b0; op = '0; th = '0; pl = '0; rdy = '0;
    repeat (2) @(posedge clk);
    started = 1'b1;
    #1 rst = 1'b0;
    sel = 1'b1; th = 3'd2; op = 5'h03; pl = 48'h1234;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      xfer  = sel && ack;
      rst_s = rst;
      @(posedge clk);
      if (rst_s) begin
        for (int t = 0; t < NTH; t++) exp_q[t].delete();
        exp_err = 1'b0;
      end else if (xfer) begin
        if (int'(th) >= NTH) exp_err = 1'b1;
        else if (op != 5'h00) exp_q[int'(th)].push_back({op, pl});
      end
      #1;
      if (c < 3) rdy = '0;
      else begin
        case ((c / 400) % 3)
          0: for (int t = 0; t < NTH; t++) rdy[t] = ($urandom_range(0, 99) < 25);
          1: rdy = '1;
          default: for (int t = 0; t < NTH; t++) rdy[t] = ($urandom_range(0, 99) < 60);
        endcase
      end
      rst = ((c % 900) == 850);
      if (xfer) begin
        sel = ($urandom_range(0, 99) < 75);
        if (sel) new_cmd();
      end else if (!sel && $urandom_range(0, 99) < 60) begin
        sel = 1'b1;
        new_cmd();
      end
    end
    #1 sel = 1'b0; rdy = '1; rst = 1'b0;
    repeat (DEPTH + 4) @(posedge clk);
    @(negedge clk);
    for (int t = 0; t < NTH; t++) chk($sformatf("drained[%0d]", t), 64'(exp_q[t].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
